// File: rtl/bcd_display_scan.sv
// Four-digit multiplexed 7-segment scanner for a BCD value.
// A loaded value waits in a pending register and is promoted to the
// displayed register only at a frame wrap, or at any edge while scanning
// is disabled. This keeps a frame from mixing two values.
module bcd_display_scan #(
    parameter int PRESCALE = 50000,
    parameter int DEAD     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] bcd_in,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        err,
    output logic        frame_done
);

    localparam logic [15:0] PMAX   = 16'(PRESCALE - 1);
    localparam logic [15:0] DEAD_C = 16'(DEAD);

    // Active-low gfedcba patterns; any non-BCD nibble shows "E".
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: seg_code = 7'h06;
        endcase
    endfunction

    logic [15:0] pend_q, pend_d;
    logic        pend_v_q, pend_v_d;
    logic [15:0] disp_q, disp_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  an_q, an_d;
    logic        err_q, err_d;
    logic        fd_q, fd_d;

    logic        slot_end;
    logic        wrap;
    logic [3:0]  lz;
    logic        blank;
    logic [3:0]  nib;

    // Slot timing, value promotion and the registered display outputs.
    always_comb begin
        slot_end = (pcnt_q == PMAX);
        wrap     = en && slot_end && (idx_q == 2'd3);

        pcnt_d = pcnt_q;
        idx_d  = idx_q;
        if (!en) begin
            pcnt_d = '0;
            idx_d  = '0;
        end else if (slot_end) begin
            pcnt_d = '0;
            idx_d  = idx_q + 2'd1;
        end else begin
            pcnt_d = pcnt_q + 16'd1;
        end

        fd_d = wrap;

        // A load coinciding with a promotion point bypasses pend entirely.
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        disp_d   = disp_q;
        if (!en || wrap) begin
            if (load) begin
                pend_d   = bcd_in;
                disp_d   = bcd_in;
                pend_v_d = 1'b0;
            end else if (pend_v_q) begin
                disp_d   = pend_q;
                pend_v_d = 1'b0;
            end
        end else if (load) begin
            pend_d   = bcd_in;
            pend_v_d = 1'b1;
        end

        // lz[k]: digits k..3 all zero; digit 0 is never blanked.
        lz[0] = 1'b0;
        lz[1] = (disp_q[15:4]  == 12'd0);
        lz[2] = (disp_q[15:8]  == 8'd0);
        lz[3] = (disp_q[15:12] == 4'd0);
        blank = blank_lz && lz[idx_q];
        nib   = disp_q[{idx_q, 2'b00} +: 4];

        seg_d = 7'h7F;
        an_d  = 4'hF;
        if (en && !blank) begin
            seg_d = seg_code(nib);
            if (pcnt_q >= DEAD_C)
                an_d[idx_q] = 1'b0;
        end

        err_d = (disp_q[3:0] > 4'd9) || (disp_q[7:4] > 4'd9) ||
                (disp_q[11:8] > 4'd9) || (disp_q[15:12] > 4'd9);
    end

    // State register; reset drops any pending value and blanks the display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            disp_q   <= '0;
            pcnt_q   <= '0;
            idx_q    <= '0;
            seg_q    <= 7'h7F;
            an_q     <= 4'hF;
            err_q    <= 1'b0;
            fd_q     <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            disp_q   <= disp_d;
            pcnt_q   <= pcnt_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            err_q    <= err_d;
            fd_q     <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign err        = err_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with PRESCALE=4, DEAD=1 (16-cycle frame).
// Expected per-cycle outputs are queued before each edge and popped after it.
module tb_bcd_display_scan;

    localparam int PRESCALE = 4;
    localparam int DEAD     = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] bcd_in;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        err;
    logic        frame_done;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] an;
        logic       fd;
        logic       err;
        logic       chk_err;
    } exp_t;

    exp_t exp_q[$];

    bcd_display_scan #(.PRESCALE(PRESCALE), .DEAD(DEAD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .bcd_in     (bcd_in),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .an         (an),
        .err        (err),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] lut [10];
        lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        if (d > 4'd9) return 7'h06;
        return lut[d];
    endfunction

    function automatic logic any_bad(input logic [15:0] v);
        logic b;
        b = 1'b0;
        for (int i = 0; i < 4; i++)
            if (v[i*4 +: 4] > 4'd9) b = 1'b1;
        return b;
    endfunction

    // One full 16-cycle frame, with up to two loads at chosen cycles.
    // dv is the value expected on the display for this frame.
    task automatic run_frame(input string name, input logic [15:0] dv,
                             input int lk1, input logic [15:0] lv1,
                             input int lk2, input logic [15:0] lv2);
        exp_t e;
        int   slot, ph;
        logic bl;
        logic [15:0] hi;
        for (int k = 0; k < 16; k++) begin
            slot = k / 4;
            ph   = k % 4;
            hi   = dv >> (4 * slot);
            bl   = blank_lz && (slot > 0) && (hi == 16'd0);
            e.seg     = bl ? 7'h7F : seg_of(dv[slot*4 +: 4]);
            e.an      = (ph >= DEAD && !bl) ? ~(4'b0001 << slot) : 4'hF;
            e.fd      = (k == 15);
            e.err     = any_bad(dv);
            e.chk_err = (k > 0);
            exp_q.push_back(e);

            load   = (k == lk1) || (k == lk2);
            bcd_in = (k == lk1) ? lv1 : lv2;
            tick();
            load = 1'b0;

            e = exp_q.pop_front();
            check({name, "_seg"}, 16'(seg), 16'(e.seg));
            check({name, "_an"}, 16'(an), 16'(e.an));
            check({name, "_fd"}, 16'(frame_done), 16'(e.fd));
            if (e.chk_err) check({name, "_err"}, 16'(err), 16'(e.err));
            check({name, "_an_onehot"}, 16'($countones(~an) <= 1), 16'd1);
        end
    endtask

    initial begin
        rst_n    = 1'b1;
        en       = 1'b0;
        load     = 1'b0;
        bcd_in   = '0;
        blank_lz = 1'b0;

        // Reset values without any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("rst_seg", 16'(seg), 16'h7F);
        check("rst_an", 16'(an), 16'hF);
        check("rst_err", 16'(err), 16'd0);
        check("rst_fd", 16'(frame_done), 16'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Load while disabled; display stays dark.
        load   = 1'b1;
        bcd_in = 16'h0123;
        tick();
        load = 1'b0;
        check("dis_seg", 16'(seg), 16'h7F);
        check("dis_an", 16'(an), 16'hF);
        tick();
        check("dis_fd", 16'(frame_done), 16'd0);

        // Scan 0123: seg 30,24,79,40 across slots 0..3.
        en = 1'b1;
        run_frame("scan", 16'h0123, -1, 0, -1, 0);

        // Tear-free: load in slot 1 shows only after the wrap.
        run_frame("tear_old", 16'h0123, 5, 16'h0456, -1, 0);
        run_frame("tear_new", 16'h0456, -1, 0, -1, 0);

        // Load at the wrap edge lands directly, pend_v left clear.
        run_frame("wrapld", 16'h0456, 15, 16'h0999, -1, 0);
        check("wrapld_pend_v", 16'(dut.pend_v_q), 16'd0);
        run_frame("wrapld_show", 16'h0999, 3, 16'h0111, 8, 16'h0222);
        run_frame("last_wins", 16'h0222, -1, 0, -1, 0);

        // Leading-zero blanking.
        blank_lz = 1'b1;
        run_frame("lz_0222", 16'h0222, 2, 16'h0007, -1, 0);
        run_frame("lz_0007", 16'h0007, 9, 16'h0000, -1, 0);
        run_frame("lz_0000", 16'h0000, 4, 16'h0A05, -1, 0);
        blank_lz = 1'b0;

        // Non-BCD nibble shows E and raises err; cleared by a valid load.
        run_frame("inv_0a05", 16'h0A05, 6, 16'h0005, -1, 0);
        run_frame("inv_clr", 16'h0005, -1, 0, -1, 0);

        // Disable mid-stream: dark outputs, no frame pulse, counters parked.
        en = 1'b0;
        tick();
        check("off_seg", 16'(seg), 16'h7F);
        check("off_an", 16'(an), 16'hF);
        check("off_fd", 16'(frame_done), 16'd0);
        tick();
        en = 1'b1;
        run_frame("reen", 16'h0005, 2, 16'h0A00, -1, 0);
        run_frame("reen_e", 16'h0A00, -1, 0, -1, 0);

        // Mid-scan reset with a pending value and err high.
        load   = 1'b1;
        bcd_in = 16'h1234;
        tick();
        load = 1'b0;
        tick();
        check("pre_rst_err", 16'(err), 16'd1);
        rst_n = 1'b0;
        #1;
        check("mrst_seg", 16'(seg), 16'h7F);
        check("mrst_an", 16'(an), 16'hF);
        check("mrst_err", 16'(err), 16'd0);
        check("mrst_fd", 16'(frame_done), 16'd0);
        check("mrst_pend_v", 16'(dut.pend_v_q), 16'd0);
        tick();
        tick();
        rst_n = 1'b1;
        run_frame("post_rst", 16'h0000, -1, 0, -1, 0);
        run_frame("post_rst2", 16'h0000, -1, 0, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_display_scan.md
BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 50000: clock cycles per digit slot; legal range 2..65535.
REQ-002 The block SHALL have parameter DEAD, default 16: anode-off cycles at the start of each slot, to prevent ghosting; legal range 0..PRESCALE-1.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port en, input, 1 bit: scan enable.
REQ-006 Port load, input, 1 bit: capture strobe for bcd_in.
REQ-007 Port bcd_in, input, 16 bits: four BCD digits, [3:0]=digit0 (ones) .. [15:12]=digit3; this is the 16-bit sum output of the 3-digit BCD adder stage.
REQ-008 Port blank_lz, input, 1 bit: leading-zero blanking enable.
REQ-009 Port seg, output, 7 bits: segments, active-low, order gfedcba.
REQ-010 Port an, output, 4 bits: digit anodes, active-low; an[k] drives digit k.
REQ-011 Port err, output, 1 bit: high while any displayed nibble is greater than 9.
REQ-012 Port frame_done, output, 1 bit: one-cycle pulse at each frame wrap.

Function
REQ-013 Internal state SHALL be: pend (16 bits), pend_v (1 bit), disp (16 bits), pcnt (16 bits), idx (2 bits).
REQ-014 load=1 at an edge SHALL write pend<=bcd_in and set pend_v; back-to-back loads overwrite pend, so the last value wins.
REQ-015 With en=1, pcnt SHALL count 0..PRESCALE-1 and then wrap to 0.
REQ-016 idx SHALL advance by 1 (mod 4) on each pcnt wrap.
REQ-017 Frame wrap SHALL be defined as pcnt=PRESCALE-1 and idx=3; at that edge the block SHALL:
- set idx<=0 and pcnt<=0;
- set frame_done<=1 for exactly one cycle;
- if pend_v=1, set disp<=pend and clear pend_v.
REQ-018 If load=1 at a frame-wrap edge, bcd_in SHALL go directly to disp and pend_v SHALL end at 0.
REQ-019 disp SHALL change only at frame wrap, or while en=0; there SHALL be no mid-frame tearing.
REQ-020 With en=0:
- pcnt and idx SHALL be held at 0;
- frame_done SHALL be 0;
- a pending value SHALL transfer to disp at every edge;
- seg SHALL be 7'h7F and an SHALL be 4'hF.
REQ-021 Digit k SHALL be blank when blank_lz=1, k>0, and disp digits k..3 are all 0; digit 0 SHALL never be lz-blanked.
REQ-022 Segment codes SHALL be:
- digits 0..9: 40,79,24,30,19,12,02,78,00,10 (hex);
- a nibble greater than 9 shows "E" = 06;
- blank = 7F.
REQ-023 seg and an SHALL be registered: at edge t they reflect idx, pcnt and disp as they stood before edge t, i.e. a one-cycle lag.
REQ-024 an[idx] SHALL be 0 only when en=1, pcnt>=DEAD, and the digit is not blank; otherwise an SHALL be 4'hF.
REQ-025 At most one an bit SHALL be low at any time.
REQ-026 err SHALL be registered from disp, and is independent of blanking and of en.

Reset
REQ-027 While rst_n=0, independent of clk, the block SHALL force:
- seg=7'h7F, an=4'hF, err=0, frame_done=0;
- pend=0, pend_v=0, disp=0, pcnt=0, idx=0.
REQ-028 Reset asserted mid-frame SHALL discard any pending value.
REQ-029 After rst_n rises, the first slot SHALL begin at idx=0, pcnt=0.

Verification (PRESCALE=4, DEAD=1 unless stated)
REQ-030 Reset mid-scan, with pend_v=1 -> outputs 7F/F/0/0 immediately, with no clock required; the first frame after release shows 0000.
REQ-031 Scan: en=1, load 16'h0123 while en=0, blank_lz=0 -> an cycles F,E,E,E,F,D,D,D,F,B,B,B,F,7,7,7; seg shows 30,24,79,40 during the lit cycles; frame_done pulses every 16 cycles.
REQ-032 Blanking: disp=16'h0007 with blank_lz=1 -> only digit 0 is lit (seg 78); digits 1..3 keep an=F for the whole frame. disp=16'h0000 -> digit 0 shows 40.
REQ-033 Tear-free update: load 16'h0456 at idx=1 -> disp is unchanged until the next frame_done; the new value appears starting in the slot after the wrap.
REQ-034 Load exactly at the wrap edge: 16'h0999 -> visible in the next frame with pend_v=0. A second load, 16'h0111, then 16'h0222 within the same frame -> only 0222 is shown.
REQ-035 Invalid input: load 16'h0A05 -> after the wrap, err=1 and digit 2 shows 06. A later load of 16'h0005 -> err=0 after the next wrap.
